// File: rtl/snake_move_if.sv
// snake_move_if: player/collision/renderer signals of snake_move_controller.
// SNAKE_PAUSE_EN adds the pause input.
interface snake_move_if;
  logic         start;
  logic [1:0]   dir1, dir2;
  logic         grow1, grow2;
  logic         should_stop1, should_stop2;
  logic [159:0] snake1, snake2;
  logic         move_strobe, running, game_over;
  logic [1:0]   winner;
`ifdef SNAKE_PAUSE_EN
  logic         pause;
`endif
  modport master(
`ifdef SNAKE_PAUSE_EN
    output pause,
`endif
    output start, dir1, dir2, grow1, grow2, should_stop1, should_stop2,
    input snake1, snake2, move_strobe, running, game_over, winner);
  modport slave(
`ifdef SNAKE_PAUSE_EN
    input pause,
`endif
    input start, dir1, dir2, grow1, grow2, should_stop1, should_stop2,
    output snake1, snake2, move_strobe, running, game_over, winner);
endinterface

// File: rtl/snake_move_controller.sv
// snake_move_controller: two-player snake sequencer (tick, move, collision check, game over).
// Define SNAKE_PAUSE_EN to add a pause input that freezes the tick counter in RUN.
module snake_move_controller #(
  parameter int TICK_DIV = 25_000_000,
  parameter int GRID_W = 30,
  parameter int GRID_H = 30,
  parameter int CHECK_LAT = 1,
  parameter logic [159:0] INIT1 = {{14{10'h3FF}}, 10'h001, 10'h002},
  parameter logic [159:0] INIT2 = {{14{10'h3FF}}, 10'h3BC, 10'h3BD}
) (
  input logic clk,
  input logic rst,
  snake_move_if.slave bus
);
  typedef enum logic [2:0] {IDLE, RUN, MOVE, CHECK, OVER} state_t;
  localparam int CW = $clog2(TICK_DIV + CHECK_LAT + 1);
  localparam logic [4:0] XM = 5'(GRID_W - 1);
  localparam logic [4:0] YM = 5'(GRID_H - 1);
  state_t r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [159:0] r_snake1, r_snake2, w_move1, w_move2;
  logic [4:0] r_len1, r_len2;
  logic [1:0] r_dir1, r_dir2, r_winner;
  logic r_pend1, r_pend2, w_keep1, w_keep2, w_pause, w_start, w_tick, w_sample;
  function automatic logic [9:0] step(input logic [9:0] h, input logic [1:0] d);
    logic [4:0] x, y;
    x = h[9:5];
    y = h[4:0];
    x = d == 2'b10 ? (x == 5'd0 ? XM : x - 5'd1) : d == 2'b11 ? (x == XM ? 5'd0 : x + 5'd1) : x;
    y = d == 2'b00 ? (y == 5'd0 ? YM : y - 5'd1) : d == 2'b01 ? (y == YM ? 5'd0 : y + 5'd1) : y;
    return {x, y};
  endfunction
  // Shift the body by one slot; unless growing, blank the slot the old tail landed in.
  function automatic logic [159:0] advance(input logic [159:0] b, input logic [1:0] d,
                                           input logic [4:0] len, input logic keep);
    logic [159:0] r;
    r = {b[149:0], step(b[9:0], d)};
    if (!keep && len < 5'd16) r[int'(len) * 10 +: 10] = 10'h3FF;
    return r;
  endfunction
  function automatic logic is_rev(input logic [1:0] req, input logic [1:0] cur);
    return req == {cur[1], ~cur[0]};
  endfunction
`ifdef SNAKE_PAUSE_EN
  assign w_pause = bus.pause;
`else
  assign w_pause = 1'b0;
`endif
  always_comb begin
    w_start = bus.start && (r_state == IDLE || r_state == OVER);
    w_tick = r_state == RUN && !w_pause && r_cnt == CW'(TICK_DIV - 1);
    w_sample = r_state == CHECK && r_cnt == CW'(CHECK_LAT);
    w_keep1 = (r_pend1 || bus.grow1) && r_len1 != 5'd16;
    w_keep2 = (r_pend2 || bus.grow2) && r_len2 != 5'd16;
    w_move1 = advance(r_snake1, r_dir1, r_len1, w_keep1);
    w_move2 = advance(r_snake2, r_dir2, r_len2, w_keep2);
    w_next = w_start ? RUN : w_tick ? MOVE : r_state == MOVE ? CHECK :
             w_sample ? ((bus.should_stop1 || bus.should_stop2) ? OVER : RUN) : r_state;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_snake1 <= INIT1;
      r_snake2 <= INIT2;
      r_len1 <= 5'd2;
      r_len2 <= 5'd2;
      r_dir1 <= 2'b01;
      r_dir2 <= 2'b00;
      r_winner <= 2'b00;
      r_pend1 <= 1'b0;
      r_pend2 <= 1'b0;
    end else if (w_start) begin
      r_cnt <= '0;
      r_snake1 <= INIT1;
      r_snake2 <= INIT2;
      r_len1 <= 5'd2;
      r_len2 <= 5'd2;
      r_dir1 <= 2'b01;
      r_dir2 <= 2'b00;
      r_winner <= 2'b00;
      r_pend1 <= 1'b0;
      r_pend2 <= 1'b0;
    end else if (r_state == RUN) begin
      if (!is_rev(bus.dir1, r_dir1)) r_dir1 <= bus.dir1;
      if (!is_rev(bus.dir2, r_dir2)) r_dir2 <= bus.dir2;
      if (!w_pause) r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
      r_pend1 <= r_pend1 | bus.grow1;
      r_pend2 <= r_pend2 | bus.grow2;
    end else if (r_state == MOVE) begin
      r_snake1 <= w_move1;
      r_snake2 <= w_move2;
      r_len1 <= w_keep1 ? r_len1 + 5'd1 : r_len1;
      r_len2 <= w_keep2 ? r_len2 + 5'd1 : r_len2;
      r_pend1 <= 1'b0;
      r_pend2 <= 1'b0;
      r_cnt <= '0;
    end else if (r_state == CHECK) begin
      r_cnt <= w_sample ? '0 : r_cnt + 1'b1;
      if (w_sample) r_winner <= {bus.should_stop1, bus.should_stop2};
      r_pend1 <= r_pend1 | bus.grow1;
      r_pend2 <= r_pend2 | bus.grow2;
    end
  end
  assign bus.snake1 = r_snake1;
  assign bus.snake2 = r_snake2;
  assign bus.move_strobe = r_state == MOVE;
  assign bus.running = r_state == RUN || r_state == MOVE || r_state == CHECK;
  assign bus.game_over = r_state == OVER;
  assign bus.winner = r_winner;
endmodule

// File: tb/tb_snake_move_controller.sv
// tb_snake_move_controller: directed bench for snake_move_controller with TICK_DIV=4.
module tb_snake_move_controller;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int vecs = 0;
  int fails = 0;
  localparam logic [159:0] INIT1 = {{14{10'h3FF}}, 10'h001, 10'h002};
  localparam logic [159:0] INIT2 = {{14{10'h3FF}}, 10'h3BC, 10'h3BD};
  snake_move_if bus();
  snake_move_controller #(.TICK_DIV(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [9:0] seg(input logic [159:0] v, input int i);
    return v[i * 10 +: 10];
  endfunction
  // Returns at the negedge after a move, with the new vectors visible (first CHECK cycle).
  task automatic wait_strobe;
    int n = 0;
    while (!bus.move_strobe && n < 40) begin
      @(negedge clk);
      n++;
    end
    vecs++;
    if (bus.move_strobe !== 1'b1) begin fails++; $display("FAIL strobe_timeout got=%b exp=1", bus.move_strobe); end
    @(negedge clk);
  endtask
  task automatic pulse_grow1;
    bus.grow1 = 1'b1;
    @(negedge clk);
    bus.grow1 = 1'b0;
  endtask
  task automatic test_reset;
    bus.start = 0; bus.dir1 = 2'b01; bus.dir2 = 2'b00; bus.grow1 = 0; bus.grow2 = 0;
    bus.should_stop1 = 0; bus.should_stop2 = 0;
`ifdef SNAKE_PAUSE_EN
    bus.pause = 0;
`endif
    repeat (2) @(negedge clk);
    vecs++; if (bus.snake1 !== INIT1) begin fails++; $display("FAIL reset_snake1 got=%h exp=%h", bus.snake1, INIT1); end
    vecs++; if (bus.snake2 !== INIT2) begin fails++; $display("FAIL reset_snake2 got=%h exp=%h", bus.snake2, INIT2); end
    vecs++; if ({bus.move_strobe, bus.running, bus.game_over, bus.winner} !== 5'b0)
      begin fails++; $display("FAIL reset_flags got=%b exp=00000", {bus.move_strobe, bus.running, bus.game_over, bus.winner}); end
    rst = 0;
    repeat (3) @(negedge clk);
    vecs++; if (bus.running !== 1'b0) begin fails++; $display("FAIL idle_hold got=%b exp=0", bus.running); end
  endtask
  task automatic test_first_move;
    bus.start = 1;
    repeat (4) @(negedge clk);
    vecs++; if (bus.move_strobe !== 1'b0) begin fails++; $display("FAIL strobe_early got=%b exp=0", bus.move_strobe); end
    @(negedge clk);
    vecs++; if ({bus.move_strobe, bus.running} !== 2'b11) begin fails++; $display("FAIL strobe_at_4 got=%b exp=11", {bus.move_strobe, bus.running}); end
    bus.start = 0;
    @(negedge clk);
    vecs++; if ({seg(bus.snake1, 0), seg(bus.snake1, 1), seg(bus.snake1, 2)} !== {10'h003, 10'h002, 10'h3FF})
      begin fails++; $display("FAIL move1_snake1 got=%h exp=%h", bus.snake1[29:0], {10'h3FF, 10'h002, 10'h003}); end
    vecs++; if ({seg(bus.snake2, 0), seg(bus.snake2, 1), seg(bus.snake2, 2)} !== {10'h3BC, 10'h3BD, 10'h3FF})
      begin fails++; $display("FAIL move1_snake2 got=%h exp=%h", bus.snake2[29:0], {10'h3FF, 10'h3BD, 10'h3BC}); end
  endtask
  task automatic test_direction;
    bus.dir1 = 2'b00;
    wait_strobe();
    vecs++; if (seg(bus.snake1, 0) !== 10'h004) begin fails++; $display("FAIL reverse_ignored got=%h exp=004", seg(bus.snake1, 0)); end
    bus.dir1 = 2'b11;
    wait_strobe();
    vecs++; if ({seg(bus.snake1, 0), seg(bus.snake1, 1), seg(bus.snake1, 2)} !== {10'h024, 10'h004, 10'h3FF})
      begin fails++; $display("FAIL turn_right got=%h exp=%h", bus.snake1[29:0], {10'h3FF, 10'h004, 10'h024}); end
  endtask
  task automatic test_grow;
    pulse_grow1();
    wait_strobe();
    vecs++; if ({seg(bus.snake1, 0), seg(bus.snake1, 2), seg(bus.snake1, 3)} !== {10'h044, 10'h004, 10'h3FF})
      begin fails++; $display("FAIL grow_keep_tail got=%h exp=%h", bus.snake1[39:0], {10'h3FF, 10'h004, 10'h024, 10'h044}); end
    for (int i = 0; i < 13; i++) begin
      pulse_grow1();
      wait_strobe();
    end
    vecs++; if ({seg(bus.snake1, 0), seg(bus.snake1, 15)} !== {10'h1E4, 10'h004})
      begin fails++; $display("FAIL grow_len16 got=%h/%h exp=1e4/004", seg(bus.snake1, 0), seg(bus.snake1, 15)); end
    pulse_grow1();
    wait_strobe();
    vecs++; if ({seg(bus.snake1, 0), seg(bus.snake1, 14), seg(bus.snake1, 15)} !== {10'h204, 10'h044, 10'h024})
      begin fails++; $display("FAIL grow_saturate got=%h/%h/%h exp=204/044/024", seg(bus.snake1, 0), seg(bus.snake1, 14), seg(bus.snake1, 15)); end
  endtask
  task automatic test_wrap;
    bus.dir1 = 2'b01;
    wait_strobe();
    bus.dir1 = 2'b11;
    repeat (13) wait_strobe();
    vecs++; if (seg(bus.snake1, 0) !== 10'h3A5) begin fails++; $display("FAIL reach_29_5 got=%h exp=3a5", seg(bus.snake1, 0)); end
    wait_strobe();
    vecs++; if (seg(bus.snake1, 0) !== 10'h005) begin fails++; $display("FAIL wrap_right got=%h exp=005", seg(bus.snake1, 0)); end
    repeat (4) wait_strobe();
    bus.dir1 = 2'b00;
    repeat (5) wait_strobe();
    vecs++; if (seg(bus.snake1, 0) !== 10'h080) begin fails++; $display("FAIL reach_4_0 got=%h exp=080", seg(bus.snake1, 0)); end
    wait_strobe();
    vecs++; if (seg(bus.snake1, 0) !== 10'h09D) begin fails++; $display("FAIL wrap_up got=%h exp=09d", seg(bus.snake1, 0)); end
  endtask
  task automatic test_stop;
    repeat (2) @(negedge clk);
    bus.should_stop1 = 1;
    repeat (2) @(negedge clk);
    vecs++; if ({bus.running, bus.game_over} !== 2'b10) begin fails++; $display("FAIL stop_ignored_in_run got=%b exp=10", {bus.running, bus.game_over}); end
    wait_strobe();
    repeat (2) @(negedge clk);
    vecs++; if ({bus.running, bus.game_over, bus.winner} !== 4'b0110) begin fails++; $display("FAIL over_winner2 got=%b exp=0110", {bus.running, bus.game_over, bus.winner}); end
    repeat (10) @(negedge clk);
    vecs++; if (seg(bus.snake1, 0) !== 10'h09C) begin fails++; $display("FAIL over_frozen got=%h exp=09c", seg(bus.snake1, 0)); end
  endtask
  task automatic test_restart;
    bus.should_stop1 = 0; bus.dir1 = 2'b01; bus.dir2 = 2'b00; bus.start = 1;
    @(negedge clk);
    bus.start = 0;
    vecs++; if ({bus.running, bus.game_over, bus.winner} !== 4'b1000) begin fails++; $display("FAIL restart_flags got=%b exp=1000", {bus.running, bus.game_over, bus.winner}); end
    vecs++; if ({bus.snake1, bus.snake2} !== {INIT1, INIT2}) begin fails++; $display("FAIL restart_init got=%h exp=%h", bus.snake1, INIT1); end
    bus.should_stop1 = 1; bus.should_stop2 = 1;
    wait_strobe();
    vecs++; if (seg(bus.snake1, 0) !== 10'h003) begin fails++; $display("FAIL restart_dir got=%h exp=003", seg(bus.snake1, 0)); end
    repeat (2) @(negedge clk);
    vecs++; if ({bus.game_over, bus.winner} !== 3'b111) begin fails++; $display("FAIL draw got=%b exp=111", {bus.game_over, bus.winner}); end
    bus.should_stop1 = 0; bus.start = 1;
    @(negedge clk);
    bus.start = 0;
    wait_strobe();
    repeat (2) @(negedge clk);
    vecs++; if ({bus.game_over, bus.winner} !== 3'b101) begin fails++; $display("FAIL winner1 got=%b exp=101", {bus.game_over, bus.winner}); end
    bus.should_stop2 = 0;
  endtask
`ifdef SNAKE_PAUSE_EN
  task automatic test_pause;
    logic seen = 1'b0;
    bus.start = 1;
    @(negedge clk);
    bus.start = 0; bus.pause = 1;
    repeat (20) begin
      @(negedge clk);
      seen |= bus.move_strobe;
    end
    vecs++; if ({seen, bus.running} !== 2'b01) begin fails++; $display("FAIL pause_hold got=%b exp=01", {seen, bus.running}); end
    bus.pause = 0;
    wait_strobe();
    vecs++; if (seg(bus.snake1, 0) !== 10'h003) begin fails++; $display("FAIL pause_resume got=%h exp=003", seg(bus.snake1, 0)); end
  endtask
`endif
  task automatic test_reset_mid_move;
    int n = 0;
    bus.start = 1;
    @(negedge clk);
    bus.start = 0;
    wait_strobe();
    @(negedge clk);
    while (!bus.move_strobe && n < 40) begin
      @(negedge clk);
      n++;
    end
    vecs++; if (bus.move_strobe !== 1'b1) begin fails++; $display("FAIL reach_move got=%b exp=1", bus.move_strobe); end
    rst = 1;
    #1;
    vecs++; if ({bus.move_strobe, bus.running, bus.game_over, bus.winner} !== 5'b0)
      begin fails++; $display("FAIL async_reset_flags got=%b exp=00000", {bus.move_strobe, bus.running, bus.game_over, bus.winner}); end
    vecs++; if ({bus.snake1, bus.snake2} !== {INIT1, INIT2}) begin fails++; $display("FAIL async_reset_vec got=%h exp=%h", bus.snake1, INIT1); end
    @(negedge clk);
    rst = 0;
  endtask
  initial begin
    test_reset();
    test_first_move();
    test_direction();
    test_grow();
    test_wrap();
    test_stop();
    test_restart();
`ifdef SNAKE_PAUSE_EN
    test_pause();
`endif
    test_reset_mid_move();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end
endmodule
